// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Each slot is BLANK_CYC all-off cycles followed by SCAN_DIV cycles of digit k.
// New words are double-buffered and only reach the display at a frame boundary.
// Optional feature: define SEG7_LZ_SUPPRESS_EN to blank leading-zero digits.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [15:0] iDATA,
  input  logic        iVALID,
  output logic        oREADY,
  output logic [3:0]  oDIG,
  input  logic [6:0]  iSEG,
  output logic [6:0]  oSEG,
  output logic [3:0]  oDIG_SEL
);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  localparam logic [19:0] SCAN_LAST  = 20'(SCAN_DIV - 1);
  localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [19:0] cnt_q, cnt_d;
  logic [15:0] pend_word_q, pend_word_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] act_word_q, act_word_d;
  logic        act_vld_q, act_vld_d;
  logic [6:0]  seg_q;
  logic [3:0]  dig_sel_q, dig_sel_d;
  logic        frame_end;
  logic        accept;
  logic        digit_lit;

  // Ready is purely the registered pending flag; no path from iVALID.
  assign accept    = iVALID && !pend_vld_q;
  assign frame_end = (state_q == ST_DRIVE) && (k_q == 2'd3) && (cnt_q == SCAN_LAST);

  // Next-state for scan timing, word buffering and the digit enables.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q + 20'd1;
    pend_word_d = pend_word_q;
    pend_vld_d  = pend_vld_q;
    act_word_d  = act_word_q;
    act_vld_d   = act_vld_q;
    digit_lit   = 1'b1;
    dig_sel_d   = 4'b1111;

    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) begin
        state_d = ST_DRIVE;
        cnt_d   = 20'd0;
      end
      default: if (cnt_q == SCAN_LAST) begin
        state_d = ST_BLANK;
        cnt_d   = 20'd0;
        k_d     = k_q + 2'd1;
      end
    endcase

    // Pending word is promoted only at the frame boundary; an empty buffer
    // lets a word accepted on that very cycle go straight to active.
    if (frame_end && pend_vld_q) begin
      act_word_d = pend_word_q;
      act_vld_d  = 1'b1;
      pend_vld_d = 1'b0;
    end else if (frame_end && accept) begin
      act_word_d = iDATA;
      act_vld_d  = 1'b1;
    end else if (accept) begin
      pend_word_d = iDATA;
      pend_vld_d  = 1'b1;
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    // Digit k>0 is dark when it and every higher nibble are zero.
    case (k_d)
      2'd1:    digit_lit = |act_word_d[15:4];
      2'd2:    digit_lit = |act_word_d[15:8];
      2'd3:    digit_lit = |act_word_d[15:12];
      default: digit_lit = 1'b1;
    endcase
`endif

    if ((state_d == ST_DRIVE) && act_vld_d && digit_lit)
      dig_sel_d = ~(4'b0001 << k_d);
  end

  // State registers; enables are registered from next-state so they align with state_q.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= ST_BLANK;
      k_q         <= 2'd0;
      cnt_q       <= 20'd0;
      pend_word_q <= 16'h0000;
      pend_vld_q  <= 1'b0;
      act_word_q  <= 16'h0000;
      act_vld_q   <= 1'b0;
      dig_sel_q   <= 4'b1111;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      pend_word_q <= pend_word_d;
      pend_vld_q  <= pend_vld_d;
      act_word_q  <= act_word_d;
      act_vld_q   <= act_vld_d;
      dig_sel_q   <= dig_sel_d;
    end
  end

  // Capture decoder output during BLANK; held through DRIVE. With no active
  // word the segments are forced off so an idle display stays fully dark.
  always_ff @(posedge iCLK) begin
    if (iRST)
      seg_q <= 7'b1111111;
    else if (state_q == ST_BLANK)
      seg_q <= act_vld_q ? iSEG : 7'b1111111;
  end

  assign oREADY   = !pend_vld_q;
  assign oDIG     = act_vld_q ? act_word_q[4*k_q +: 4] : 4'h0;
  assign oSEG     = seg_q;
  assign oDIG_SEL = dig_sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (slot 10, frame 40).
// Cycle 0 is the first cycle after reset release; the frame boundary is cycle 39.
module tb_seg7_scan_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [15:0] iDATA;
  logic        iVALID;
  logic        oREADY;
  logic [3:0]  oDIG;
  logic [6:0]  iSEG;
  logic [6:0]  oSEG;
  logic [3:0]  oDIG_SEL;

  int n_checks = 0;
  int n_pass   = 0;
  int cur      = 0;

  seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
    .oDIG(oDIG), .iSEG(iSEG), .oSEG(oSEG), .oDIG_SEL(oDIG_SEL)
  );

  always #5 iCLK = ~iCLK;

  // Reference active-low hex decoder (gfedcba).
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  assign iSEG = hex7(oDIG);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the edge that starts cycle n.
  task automatic goto(input int n);
    while (cur < n) begin
      @(posedge iCLK);
      cur++;
    end
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b1; iVALID = 1'b0; iDATA = 16'h0000;
    @(posedge iCLK); @(posedge iCLK);
    #1 iRST = 1'b0;
    cur = 0;
  endtask

  task automatic load(input int c, input logic [15:0] w);
    goto(c);
    iVALID = 1'b1; iDATA = w;
    goto(c + 1);
    iVALID = 1'b0;
  endtask

  task automatic check_slot(input string tag, input int c, input int k, input logic [6:0] seg);
    goto(c);
    check({tag, "_sel"}, {12'h0, oDIG_SEL}, {12'h0, ~(4'b0001 << k)});
    check({tag, "_seg"}, {9'h0, oSEG}, {9'h0, seg});
  endtask

  initial begin
    int bad;

    // Idle after reset: dark, ready, for two full frames.
    do_reset();
    check("rst_ready", {15'h0, oREADY}, 16'h1);
    check("rst_sel", {12'h0, oDIG_SEL}, 16'hF);
    check("rst_seg", {9'h0, oSEG}, 16'h7F);
    check("rst_dig", {12'h0, oDIG}, 16'h0);
    bad = 0;
    for (int i = 1; i <= 80; i++) begin
      goto(i);
      if (oDIG_SEL !== 4'hF || oSEG !== 7'h7F || oREADY !== 1'b1) bad++;
    end
    check("idle_dark_cycles_bad", 16'(bad), 16'h0);

    // 1234 loaded at cycle 5, shown from the boundary.
    do_reset();
    load(5, 16'h1234);
    check("ld_ready_low", {15'h0, oREADY}, 16'h0);
    goto(35);
    check("ld_dark_before", {12'h0, oDIG_SEL}, 16'hF);
    goto(39);
    check("ld_ready_low39", {15'h0, oREADY}, 16'h0);
    goto(40);
    check("ld_ready_high40", {15'h0, oREADY}, 16'h1);
    goto(41);
    check("ld_blank41", {12'h0, oDIG_SEL}, 16'hF);
    check_slot("d0_4", 42, 0, 7'b0011001);
    goto(49);
    check("d0_last", {12'h0, oDIG_SEL}, 16'hE);
    goto(50);
    check("d1_blank", {12'h0, oDIG_SEL}, 16'hF);
    check_slot("d1_3", 52, 1, 7'b0110000);
    check_slot("d2_2", 62, 2, 7'b0100100);
    check_slot("d3_1", 72, 3, 7'b1111001);

    // ABCD pending, 5678 offered mid-frame and held off until the boundary.
    do_reset();
    load(5, 16'hABCD);
    goto(20);
    iVALID = 1'b1; iDATA = 16'h5678;
    goto(21);
    check("hold_ready21", {15'h0, oREADY}, 16'h0);
    goto(39);
    check("hold_ready39", {15'h0, oREADY}, 16'h0);
    goto(40);
    check("hold_ready40", {15'h0, oREADY}, 16'h1);
    goto(41);
    iVALID = 1'b0;
    check("hold_ready41", {15'h0, oREADY}, 16'h0);
    check_slot("ab_d", 45, 0, 7'b0100001);
    check_slot("ab_c", 55, 1, 7'b1000110);
    check_slot("ab_b", 65, 2, 7'b0000011);
    check_slot("ab_a", 75, 3, 7'b0001000);
    check_slot("nx_8", 85, 0, 7'b0000000);
    check_slot("nx_7", 95, 1, 7'b1111000);

    // Word offered exactly on the boundary with nothing pending.
    do_reset();
    goto(39);
    check("bnd_ready39", {15'h0, oREADY}, 16'h1);
    iVALID = 1'b1; iDATA = 16'h4321;
    goto(40);
    iVALID = 1'b0;
    check("bnd_ready40", {15'h0, oREADY}, 16'h1);
    check("bnd_dig40", {12'h0, oDIG}, 16'h1);
    goto(41);
    check("bnd_ready41", {15'h0, oREADY}, 16'h1);
    check_slot("bnd_1", 42, 0, 7'b1111001);
    check_slot("bnd_4", 72, 3, 7'b0011001);

    // Leading zeros: 0050.
    do_reset();
    load(5, 16'h0050);
    check_slot("lz_d0", 45, 0, 7'b1000000);
    check_slot("lz_d1", 55, 1, 7'b0010010);
`ifdef SEG7_LZ_SUPPRESS_EN
    goto(65);
    check("lz_d2_dark", {12'h0, oDIG_SEL}, 16'hF);
    goto(75);
    check("lz_d3_dark", {12'h0, oDIG_SEL}, 16'hF);
`else
    check_slot("lz_d2", 65, 2, 7'b1000000);
    check_slot("lz_d3", 75, 3, 7'b1000000);
`endif

    // Reset during DRIVE of digit 2 with a word pending.
    do_reset();
    load(5, 16'h1234);
    load(45, 16'h5678);
    check("mr_pending", {15'h0, oREADY}, 16'h0);
    goto(63);
    check("mr_lit_before", {12'h0, oDIG_SEL}, 16'hB);
    iRST = 1'b1;
    @(posedge iCLK);
    #1 iRST = 1'b0;
    cur = 0;
    check("mr_ready", {15'h0, oREADY}, 16'h1);
    check("mr_sel", {12'h0, oDIG_SEL}, 16'hF);
    check("mr_seg", {9'h0, oSEG}, 16'h7F);
    check("mr_dig", {12'h0, oDIG}, 16'h0);
    bad = 0;
    for (int i = 1; i <= 80; i++) begin
      goto(i);
      if (oDIG_SEL !== 4'hF || oSEG !== 7'h7F) bad++;
    end
    check("mr_dark_cycles_bad", 16'(bad), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
